bcd_serial_add_ctrl: RTL and testbench
======================================

Name: bcd_serial_add_ctrl

Overview:
- Sequences one shared single-digit BCD adder across multi-digit operands to produce a multi-digit BCD sum.
- Feeds one digit pair per clock, least-significant digit first, and ripples the carry between digits in a register.
- Sits between operand sources (switches/registers) and the display path; the display driver reads its result register.
- The adder is external and purely combinational; this block only drives it and captures its outputs.

Parameters:
- DIGITS, 4, number of BCD digits per operand (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request to begin an addition; sampled only in IDLE.
- a  in  4*DIGITS  operand A, packed BCD, digit 0 in [3:0].
- b  in  4*DIGITS  operand B, packed BCD.
- cin  in  1  initial carry into digit 0.
- add_x  out  4  digit of A driven to the shared adder.
- add_y  out  4  digit of B driven to the shared adder.
- add_cin  out  1  carry driven to the shared adder.
- add_s  in  4  sum digit returned by the adder, combinational, same cycle.
- add_cout  in  1  carry returned by the adder.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when the result is final.
- result  out  4*DIGITS  packed BCD sum; holds until the next accepted start.
- cout  out  1  final carry out of the top digit.
- err  out  1  operand digit >9 or adder returned digit >9; holds until the next accepted start.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - result=0, cout=0, err=0, busy=0, done=0.
  - add_x, add_y and add_cin are 0.
  - Internal digit index and carry are 0.
- States and transitions:
  - IDLE: start=1 accepts the request (cycle 0).
    - Latch a, b and cin into internal operand registers.
    - Clear result, cout and err.
    - Set idx=0 and carry=cin.
    - If any latched digit of a or b is >9: set err=1 and go to DONE, skipping RUN. Result stays 0 and cout stays 0.
    - Otherwise go to RUN.
  - RUN (busy=1), one digit per cycle:
    - Drive add_x=A[idx], add_y=B[idx], add_cin=carry.
    - On the clock edge: result[idx] <= add_s, carry <= add_cout, idx <= idx+1.
    - If add_s>9: err<=1 and go to DONE immediately; digits above idx remain 0 and cout=0.
    - When idx==DIGITS-1: cout <= add_cout and go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE unconditionally.
- Adder drive outside RUN: add_x, add_y and add_cin are 0 in IDLE and DONE.
- Latency:
  - Accepted start at cycle 0; RUN occupies cycles 1..DIGITS; done pulses in cycle DIGITS+1.
  - For DIGITS=4, done is high in cycle 5.
  - On an operand error, done pulses in cycle 1.
- Input stability: changes to start, a, b or cin while busy or in DONE are ignored. Operands are used only from the latched copy.
- Back-to-back requests: start held high continuously re-arms in the IDLE cycle after DONE. Throughput is one addition per DIGITS+2 cycles.
- Result visibility: result is updated digit-by-digit during RUN. Consumers use it only on or after done.
- Reset mid-operation: asynchronous abort. All outputs return to reset values, no done pulse, and the partial result is discarded.
- Index counter width: clog2(DIGITS); it never exceeds DIGITS-1.

Test Plan:
- DIGITS=4, a=0x1234, b=0x5678, cin=0, start one cycle -> busy cycles 1-4, done in cycle 5, result=0x6912, cout=0, err=0.
- a=0x9999, b=0x0001, cin=0 -> the carry ripples through all digits; result=0x0000, cout=1, done in cycle 5.
- a=0x0000, b=0x0000, cin=1 -> result=0x0001, cout=0. Also check add_cin=1 only in cycle 1.
- a=0x12A4, b=0x0000 -> err=1, result=0, busy never high, done in cycle 1; add_x/add_y stay 0 throughout.
- Start pulsed again in cycles 2-3 with different operands -> ignored; result is still from the first operands. A new start in the IDLE cycle after done is accepted.
- Adder model forced to return add_s=0xB at digit 1 -> err=1, result[3:0] valid, upper digits 0, done the following cycle.
- rst_n low in cycle 2 of a run -> busy, result, cout and err drop to 0 immediately; no done pulse; the next start runs normally.

Source files
------------

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD addition controller.
// Drives one shared combinational single-digit BCD adder, one digit pair per
// clock, least-significant digit first, rippling the carry through a register.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   start, a, b, cin        request and operands (packed BCD, digit 0 in [3:0])
//   add_x, add_y, add_cin   digit pair and carry presented to the shared adder
//   add_s, add_cout         adder result (combinational, same cycle)
//   busy, done              RUN indicator, one-cycle completion pulse
//   result, cout, err       packed BCD sum, final carry, invalid-digit flag
module bcd_serial_add_ctrl #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic [3:0]            add_x,
    output logic [3:0]            add_y,
    output logic                  add_cin,
    input  logic [3:0]            add_s,
    input  logic                  add_cout,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   result,
    output logic                  cout,
    output logic                  err
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   idx_inc_c;
    logic            bad_op_c;
    logic            last_c;
    logic            sum_bad_c;

    // Any operand digit outside 0..9 on the incoming request
    always_comb begin
        bad_op_c = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) begin
                bad_op_c = 1'b1;
            end
        end
    end

    always_comb begin
        last_c    = (idx == IW'(DIGITS - 1));
        sum_bad_c = (add_s > 4'd9);
        idx_inc_c = idx + IW'(1);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = bad_op_c ? DONE : RUN;
            RUN:     if (sum_bad_c || last_c) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and registered outputs. add_x/add_y are preloaded one cycle
    // ahead so the adder sees digit idx during each RUN cycle; add_cin doubles
    // as the ripple-carry register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            idx     <= '0;
            add_x   <= '0;
            add_y   <= '0;
            add_cin <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
            err     <= 1'b0;
        end else begin
            busy <= (state_nxt == RUN);
            done <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        idx    <= '0;
                        result <= '0;
                        cout   <= 1'b0;
                        err    <= bad_op_c;
                        if (!bad_op_c) begin
                            add_x   <= a[3:0];
                            add_y   <= b[3:0];
                            add_cin <= cin;
                        end
                    end
                end
                RUN: begin
                    result[4*int'(idx) +: 4] <= add_s;
                    if (sum_bad_c) begin
                        err <= 1'b1;
                    end
                    if (last_c && !sum_bad_c) begin
                        cout <= add_cout;
                    end
                    if (sum_bad_c || last_c) begin
                        idx     <= '0;
                        add_x   <= '0;
                        add_y   <= '0;
                        add_cin <= 1'b0;
                    end else begin
                        idx     <= idx_inc_c;
                        add_x   <= a_q[4*int'(idx_inc_c) +: 4];
                        add_y   <= b_q[4*int'(idx_inc_c) +: 4];
                        add_cin <= add_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl (DIGITS=4) with a behavioural
// single-digit BCD adder and an integer-arithmetic reference model.
module tb_bcd_serial_add_ctrl;

    localparam int unsigned DIGITS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic [3:0]  add_x, add_y, add_s;
    logic        add_cin, add_cout;
    logic        busy, done, cout, err;
    logic [15:0] result;

    int n_vec = 0;
    int n_err = 0;
    int inj_digit = -1;
    int dcnt = 0;

    always #5 clk = ~clk;

    bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .busy(busy), .done(done), .result(result), .cout(cout), .err(err)
    );

    // Digit position of the current RUN cycle, used for fault injection
    always @(posedge clk) begin
        if (!busy) dcnt <= 0;
        else       dcnt <= dcnt + 1;
    end

    // Behavioural single-digit BCD adder with optional forced bad digit
    logic [4:0] raw;
    logic [3:0] m_s;
    always_comb begin
        raw      = 5'(add_x) + 5'(add_y) + 5'(add_cin);
        m_s      = (raw > 5'd9) ? 4'(raw - 5'd10) : raw[3:0];
        add_cout = (raw > 5'd9);
        add_s    = (inj_digit >= 0 && busy && dcnt == inj_digit) ? 4'hB : m_s;
    end

    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r = '0;
        int t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] rand_bcd();
        logic [15:0] r = '0;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Issue one single-cycle start and observe until done (bounded)
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tbv, input logic tc,
                         output logic [15:0] r, output logic co, output logic er,
                         output int dcyc, output logic [31:0] busy_m,
                         output logic [31:0] cin_m, output bit xy_nz);
        @(negedge clk);
        a = ta; b = tbv; cin = tc; start = 1'b1;
        dcyc = -1; busy_m = '0; cin_m = '0; xy_nz = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (busy) busy_m[k] = 1'b1;
            if (add_cin) cin_m[k] = 1'b1;
            if (add_x != 4'd0 || add_y != 4'd0) xy_nz = 1'b1;
            if (done) begin
                dcyc = k;
                break;
            end
            @(negedge clk);
        end
        r = result; co = cout; er = err;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy, done, cout, err, add_cin} !== 5'b0 || result !== 16'h0 ||
            add_x !== 4'h0 || add_y !== 4'h0) begin
            n_err++;
            $display("FAIL reset: busy=%b done=%b cout=%b err=%b cin=%b result=%h x=%h y=%h, required all 0",
                     busy, done, cout, err, add_cin, result, add_x, add_y);
        end
        rst_n = 1'b1;
    endtask

    // Checks a valid (error-free) addition against the integer model
    task automatic check_valid(input string name, input logic [15:0] ta, input logic [15:0] tbv,
                               input logic tc);
        logic [15:0] r, exp_r; logic co, er, exp_co; int dcyc, s;
        logic [31:0] bm, cm; bit xy;
        s = bcd2int(ta) + bcd2int(tbv) + int'(tc);
        exp_r = int2bcd(s % 10000);
        exp_co = (s >= 10000);
        do_op(ta, tbv, tc, r, co, er, dcyc, bm, cm, xy);
        n_vec++;
        if (r !== exp_r || co !== exp_co || er !== 1'b0) begin
            n_err++;
            $display("FAIL %s sum %h+%h+%0d: result=%h cout=%b err=%b, required %h %b 0",
                     name, ta, tbv, tc, r, co, er, exp_r, exp_co);
        end
        n_vec++;
        if (dcyc !== 5 || bm !== 32'h1E) begin
            n_err++;
            $display("FAIL %s timing: done cycle=%0d busy mask=%h, required 5 and 1e",
                     name, dcyc, bm);
        end
    endtask

    task automatic test_plan_vectors();
        logic [15:0] r; logic co, er; int dcyc; logic [31:0] bm, cm; bit xy;
        check_valid("plain", 16'h1234, 16'h5678, 1'b0);
        check_valid("ripple", 16'h9999, 16'h0001, 1'b0);
        check_valid("cin_only", 16'h0000, 16'h0000, 1'b1);
        // add_cin pattern for the cin-only case
        do_op(16'h0000, 16'h0000, 1'b1, r, co, er, dcyc, bm, cm, xy);
        n_vec++;
        if (cm !== 32'h2 || r !== 16'h0001) begin
            n_err++;
            $display("FAIL cin_mask: add_cin mask=%h result=%h, required 2 0001", cm, r);
        end
        // Operand digit error
        do_op(16'h12A4, 16'h0000, 1'b0, r, co, er, dcyc, bm, cm, xy);
        n_vec++;
        if (er !== 1'b1 || r !== 16'h0 || co !== 1'b0 || dcyc !== 1 || bm !== 32'h0 || xy !== 1'b0) begin
            n_err++;
            $display("FAIL op_err: err=%b result=%h cout=%b done=%0d busy=%h xy=%b, required 1 0000 0 1 0 0",
                     er, r, co, dcyc, bm, xy);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            check_valid("random", rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_random_err();
        logic [15:0] ta, tbv, r; logic co, er; int dcyc; logic [31:0] bm, cm; bit xy;
        for (int i = 0; i < 6; i++) begin
            ta = rand_bcd(); tbv = rand_bcd();
            if ($urandom_range(0, 1) == 0) ta[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
            else tbv[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
            do_op(ta, tbv, 1'($urandom_range(0, 1)), r, co, er, dcyc, bm, cm, xy);
            n_vec++;
            if (er !== 1'b1 || r !== 16'h0 || co !== 1'b0 || dcyc !== 1 || bm !== 32'h0 || xy !== 1'b0) begin
                n_err++;
                $display("FAIL rand_op_err %h+%h: err=%b result=%h cout=%b done=%0d busy=%h, required 1 0000 0 1 0",
                         ta, tbv, er, r, co, dcyc, bm);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [15:0] r; logic co, er; int dcyc; logic [31:0] bm, cm; bit xy;
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
        dcyc = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = (k == 2 || k == 3);
            if (k == 2) begin a = 16'h9999; b = 16'h9999; cin = 1'b1; end
            if (done) begin dcyc = k; break; end
        end
        start = 1'b0;
        n_vec++;
        if (result !== 16'h6912 || cout !== 1'b0 || dcyc !== 5) begin
            n_err++;
            $display("FAIL ignore_start: result=%h cout=%b done=%0d, required 6912 0 5", result, cout, dcyc);
        end
        // Fresh request in the IDLE cycle right after done
        do_op(16'h4321, 16'h1111, 1'b0, r, co, er, dcyc, bm, cm, xy);
        n_vec++;
        if (r !== 16'h5432 || dcyc !== 5) begin
            n_err++;
            $display("FAIL restart: result=%h done=%0d, required 5432 5", r, dcyc);
        end
    endtask

    task automatic test_back_to_back();
        int d1, d2;
        logic [15:0] r1;
        d1 = -1; d2 = -1; r1 = '0;
        @(negedge clk);
        a = 16'h0101; b = 16'h0202; cin = 1'b0; start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done && d1 < 0) begin
                d1 = k; r1 = result;
                a = 16'h5005; b = 16'h4996; cin = 1'b1;
            end else if (done) begin
                d2 = k;
                start = 1'b0;
                break;
            end
        end
        start = 1'b0;
        n_vec++;
        if (d1 !== 5 || d2 !== 11 || r1 !== 16'h0303) begin
            n_err++;
            $display("FAIL back_to_back timing: done at %0d,%0d first=%h, required 5,11 0303", d1, d2, r1);
        end
        n_vec++;
        if (result !== 16'h0002 || cout !== 1'b1) begin
            n_err++;
            $display("FAIL back_to_back second: result=%h cout=%b, required 0002 1", result, cout);
        end
    endtask

    task automatic test_adder_fault();
        logic [15:0] r; logic co, er; int dcyc; logic [31:0] bm, cm; bit xy;
        inj_digit = 1;
        do_op(16'h1111, 16'h2222, 1'b0, r, co, er, dcyc, bm, cm, xy);
        inj_digit = -1;
        n_vec++;
        if (er !== 1'b1 || r[3:0] !== 4'h3 || r[15:8] !== 8'h00 || co !== 1'b0 || dcyc !== 3) begin
            n_err++;
            $display("FAIL adder_fault: err=%b result=%h cout=%b done=%0d, required 1 00?3 0 3",
                     er, r, co, dcyc);
        end
        // Error must clear on the next accepted start
        check_valid("after_fault", 16'h0450, 16'h0550, 1'b0);
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        @(negedge clk);
        a = 16'h9999; b = 16'h9999; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, cout, err} !== 4'b0 || result !== 16'h0 || add_x !== 4'h0) begin
            n_err++;
            $display("FAIL reset_mid: busy=%b done=%b cout=%b err=%b result=%h x=%h, required 0",
                     busy, done, cout, err, result, add_x);
        end
        saw_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            if (done) saw_done = 1'b1;
        end
        n_vec++;
        if (saw_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_done: done pulse=%b, required 0", saw_done);
        end
        check_valid("after_reset", 16'h2468, 16'h1357, 1'b0);
    endtask

    initial begin
        test_reset();
        test_plan_vectors();
        test_random();
        test_random_err();
        test_ignore_start();
        test_back_to_back();
        test_adder_fault();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
